// File: rtl/vl53l0x_pkg.sv
// Shared definitions for the VL53L0X ranging sequencer: register map, FSM encoding, error codes.
package vl53l0x_pkg;

   localparam logic [7:0] REG_SYSRANGE_START = 8'h00;
   localparam logic [7:0] REG_INT_STATUS     = 8'h13;
   localparam logic [7:0] REG_RESULT_RANGE   = 8'h1E;
   localparam logic [7:0] REG_INT_CLEAR      = 8'h0B;
   localparam logic [7:0] CMD_GO             = 8'h01;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_START,
      ST_WAIT_START,
      ST_RD_INT,
      ST_WAIT_INT,
      ST_POLL_GAP,
      ST_RD_RES,
      ST_WAIT_RES,
      ST_WR_CLR,
      ST_WAIT_CLR,
      ST_PERIOD_WAIT,
      ST_ERROR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_NACK    = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_code_t;

endpackage

// File: rtl/seq_timer.sv
// Down-counter with load; expired is the terminal-count compare (count == 0).
module seq_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/vl53l0x_range_sequencer.sv
// Drives a byte-level I2C master through one VL53L0X range shot: start, poll, read, clear.
//  state        | meaning
//  IDLE         | waiting for start or cont_en
//  WR_START     | issuing SYSRANGE_START <= 1
//  WAIT_START   | awaiting response to start write
//  RD_INT       | issuing interrupt-status read
//  WAIT_INT     | awaiting status; decides ready / poll again / timeout
//  POLL_GAP     | spacing between status polls
//  RD_RES       | issuing 2-byte result read
//  WAIT_RES     | awaiting result; captured into shadow
//  WR_CLR       | issuing interrupt clear
//  WAIT_CLR     | awaiting clear; publishes distance on success
//  PERIOD_WAIT  | idle spacing between continuous shots
//  ERROR        | one cycle to raise err
module vl53l0x_range_sequencer
   import vl53l0x_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h29,
   parameter int         POLL_GAP = 12500,
   parameter int         POLL_MAX = 255,
   parameter int         PERIOD   = 250000
) (
   input  logic        fastclk,
   input  logic        rst,
   input  logic        start,
   input  logic        cont_en,
   output logic        busy,
   output logic        dist_valid,
   output logic [15:0] distance,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [6:0]  cmd_dev,
   output logic        cmd_rw,
   output logic [7:0]  cmd_reg,
   output logic [7:0]  cmd_wdata,
   output logic [1:0]  cmd_rlen,
   input  logic        rsp_valid,
   input  logic        rsp_nack,
   input  logic [15:0] rsp_data
);

   localparam int TMR_MAX = (POLL_GAP > PERIOD) ? POLL_GAP : PERIOD;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int POLL_W  = $clog2(POLL_MAX + 1);
   localparam logic [TMR_W-1:0]  GAP_LOAD    = TMR_W'(POLL_GAP - 1);
   localparam logic [TMR_W-1:0]  PERIOD_LOAD = TMR_W'(PERIOD - 1);
   localparam logic [POLL_W-1:0] POLL_LAST   = POLL_W'(POLL_MAX - 1);

   state_t            state, state_next;
   err_code_t         err_code_q, code_nxt;
   logic [POLL_W-1:0] poll_cnt;
   logic [15:0]       shadow;
   logic              poll_clr, poll_inc, shadow_ld, dist_ld, start_acc, code_ld;
   logic              tmr_load, tmr_expired;
   logic [TMR_W-1:0]  tmr_val;
   logic              rsp_ok, rsp_bad;

   assign rsp_ok   = rsp_valid && !rsp_nack;
   assign rsp_bad  = rsp_valid && rsp_nack;
   assign busy     = (state != ST_IDLE);
   assign cmd_dev  = DEV_ADDR;
   assign err_code = err_code_q;

   always_ff @(posedge fastclk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_valid  = 1'b0;
      cmd_rw     = 1'b0;
      cmd_reg    = 8'h00;
      cmd_wdata  = 8'h00;
      cmd_rlen   = 2'd0;
      poll_clr   = 1'b0;
      poll_inc   = 1'b0;
      shadow_ld  = 1'b0;
      dist_ld    = 1'b0;
      start_acc  = 1'b0;
      code_ld    = 1'b0;
      code_nxt   = ERR_NONE;
      case (state)
         ST_IDLE: if (start || cont_en) begin
            start_acc  = 1'b1;
            state_next = ST_WR_START;
         end
         ST_WR_START: begin
            cmd_valid = 1'b1;
            cmd_reg   = REG_SYSRANGE_START;
            cmd_wdata = CMD_GO;
            if (cmd_ready) state_next = ST_WAIT_START;
         end
         ST_RD_INT: begin
            cmd_valid = 1'b1;
            cmd_rw    = 1'b1;
            cmd_reg   = REG_INT_STATUS;
            cmd_rlen  = 2'd1;
            if (cmd_ready) state_next = ST_WAIT_INT;
         end
         ST_RD_RES: begin
            cmd_valid = 1'b1;
            cmd_rw    = 1'b1;
            cmd_reg   = REG_RESULT_RANGE;
            cmd_rlen  = 2'd2;
            if (cmd_ready) state_next = ST_WAIT_RES;
         end
         ST_WR_CLR: begin
            cmd_valid = 1'b1;
            cmd_reg   = REG_INT_CLEAR;
            cmd_wdata = CMD_GO;
            if (cmd_ready) state_next = ST_WAIT_CLR;
         end
         ST_WAIT_START, ST_WAIT_INT, ST_WAIT_RES, ST_WAIT_CLR: begin
            if (rsp_bad) begin
               state_next = ST_ERROR;
               code_ld    = 1'b1;
               code_nxt   = ERR_NACK;
            end else if (rsp_ok) begin
               case (state)
                  ST_WAIT_START: begin
                     poll_clr   = 1'b1;
                     state_next = ST_RD_INT;
                  end
                  ST_WAIT_INT: begin
                     if (rsp_data[2:0] != 3'b000) begin
                        state_next = ST_RD_RES;
                     end else begin
                        poll_inc = 1'b1;
                        if (poll_cnt == POLL_LAST) begin
                           state_next = ST_ERROR;
                           code_ld    = 1'b1;
                           code_nxt   = ERR_TIMEOUT;
                        end else begin
                           state_next = ST_POLL_GAP;
                        end
                     end
                  end
                  ST_WAIT_RES: begin
                     shadow_ld  = 1'b1;
                     state_next = ST_WR_CLR;
                  end
                  default: begin
                     dist_ld    = 1'b1;
                     state_next = cont_en ? ST_PERIOD_WAIT : ST_IDLE;
                  end
               endcase
            end
         end
         ST_POLL_GAP: if (tmr_expired) state_next = ST_RD_INT;
         ST_PERIOD_WAIT: begin
            if (!cont_en)         state_next = ST_IDLE;
            else if (tmr_expired) state_next = ST_WR_START;
         end
         ST_ERROR: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Timer reloads on entry so each gap/period starts counting from full length.
   assign tmr_load = (state_next != state) &&
                     ((state_next == ST_POLL_GAP) || (state_next == ST_PERIOD_WAIT));
   assign tmr_val  = (state_next == ST_PERIOD_WAIT) ? PERIOD_LOAD : GAP_LOAD;

   seq_timer #(.WIDTH(TMR_W)) u_timer (
      .clk      (fastclk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge fastclk or posedge rst) begin
      if (rst) begin
         poll_cnt   <= '0;
         shadow     <= '0;
         distance   <= '0;
         dist_valid <= 1'b0;
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         dist_valid <= dist_ld;
         if (poll_clr)      poll_cnt <= '0;
         else if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
         if (shadow_ld)     shadow <= rsp_data;
         else if (code_ld)  shadow <= '0;
         if (dist_ld)       distance <= shadow;
         if (start_acc) begin
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
         end else begin
            if (state == ST_ERROR) err <= 1'b1;
            if (code_ld)           err_code_q <= code_nxt;
         end
      end
   end

endmodule

// File: tb/tb_vl53l0x_range_sequencer.sv
// Directed bench for vl53l0x_range_sequencer with a behavioural I2C-master model.
module tb_vl53l0x_range_sequencer;

   logic        fastclk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cont_en = 1'b0;
   logic        busy, dist_valid, err;
   logic [15:0] distance;
   logic [1:0]  err_code;
   logic        cmd_valid, cmd_rw;
   logic        cmd_ready = 1'b0;
   logic [6:0]  cmd_dev;
   logic [7:0]  cmd_reg, cmd_wdata;
   logic [1:0]  cmd_rlen;
   logic        rsp_valid = 1'b0;
   logic        rsp_nack = 1'b0;
   logic [15:0] rsp_data = 16'h0000;

   always #5 fastclk = ~fastclk;

   vl53l0x_range_sequencer #(
      .DEV_ADDR (7'h29),
      .POLL_GAP (5),
      .POLL_MAX (4),
      .PERIOD   (100)
   ) dut (
      .fastclk    (fastclk),
      .rst        (rst),
      .start      (start),
      .cont_en    (cont_en),
      .busy       (busy),
      .dist_valid (dist_valid),
      .distance   (distance),
      .err        (err),
      .err_code   (err_code),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dev    (cmd_dev),
      .cmd_rw     (cmd_rw),
      .cmd_reg    (cmd_reg),
      .cmd_wdata  (cmd_wdata),
      .cmd_rlen   (cmd_rlen),
      .rsp_valid  (rsp_valid),
      .rsp_nack   (rsp_nack),
      .rsp_data   (rsp_data)
   );

   // master model configuration (written by the stimulus block only)
   int          ready_delay = 0;
   int          rsp_lat = 2;
   logic        nack_en = 1'b0;
   logic [7:0]  nack_reg = 8'h00;
   logic [15:0] res_data = 16'h0000;
   logic [7:0]  stat_arr [0:15];
   logic [3:0]  stat_n = 4'd0;
   logic [7:0]  stat_default = 8'h00;
   int          stat_gen = 0;

   // monitor state (posedge block only)
   int          acc_cnt = 0, n_cmds = 0, n_rd = 0, n_int_rd = 0, n_res_rd = 0;
   int          dv_cnt = 0, cyc = 0, t_dv = 0, last_gap = -1;
   logic        have_dv = 1'b0;
   logic [7:0]  p_reg = 8'h00, last_reg = 8'h00, last_wdata = 8'h00;
   logic        p_rw = 1'b0;

   // model state (negedge block only)
   int          seen_acc = 0, wait_cnt = 0, lat_cnt = 0, stat_seen = 0;
   logic        pending = 1'b0;
   logic [3:0]  stat_idx = 4'd0;
   logic [7:0]  cur_stat;

   assign cur_stat = (stat_idx < stat_n) ? stat_arr[stat_idx] : stat_default;

   always @(posedge fastclk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (dist_valid) begin
            dv_cnt  <= dv_cnt + 1;
            t_dv    <= cyc;
            have_dv <= 1'b1;
         end
         if (cmd_valid && cmd_ready) begin
            acc_cnt    <= acc_cnt + 1;
            n_cmds     <= n_cmds + 1;
            p_reg      <= cmd_reg;
            p_rw       <= cmd_rw;
            last_reg   <= cmd_reg;
            last_wdata <= cmd_wdata;
            if (cmd_rw) n_rd <= n_rd + 1;
            if (cmd_rw && cmd_reg == 8'h13) n_int_rd <= n_int_rd + 1;
            if (cmd_rw && cmd_reg == 8'h1E) n_res_rd <= n_res_rd + 1;
            if (!cmd_rw && cmd_reg == 8'h00 && have_dv) last_gap <= cyc - t_dv;
         end
      end
   end

   always @(negedge fastclk) begin
      rsp_valid <= 1'b0;
      rsp_nack  <= 1'b0;
      if (rst) begin
         cmd_ready <= 1'b0;
         pending   <= 1'b0;
         wait_cnt  <= 0;
         seen_acc  <= acc_cnt;
      end else if (acc_cnt != seen_acc) begin
         seen_acc  <= acc_cnt;
         pending   <= 1'b1;
         cmd_ready <= 1'b0;
         wait_cnt  <= 0;
         lat_cnt   <= rsp_lat;
      end else if (pending) begin
         if (lat_cnt == 0) begin
            pending   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_nack  <= nack_en && (p_reg == nack_reg);
            if (!p_rw) begin
               rsp_data <= 16'h0000;
            end else if (p_reg == 8'h1E) begin
               rsp_data <= res_data;
            end else begin
               rsp_data <= {8'h00, cur_stat};
               stat_idx <= stat_idx + 4'd1;
            end
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end else if (cmd_valid && !cmd_ready) begin
         if (wait_cnt >= ready_delay) cmd_ready <= 1'b1;
         else                         wait_cnt  <= wait_cnt + 1;
      end
      if (stat_gen != stat_seen) begin
         stat_seen <= stat_gen;
         stat_idx  <= 4'd0;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge fastclk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge fastclk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit          ok;
      bit          stable;
      int          b_cmds, b_int, b_dv, b_res;
      logic [7:0]  s_reg, s_wdata;
      logic        s_rw;
      logic [1:0]  s_rlen;

      for (int i = 0; i < 16; i++) stat_arr[i] = 8'h00;
      res_data    = 16'h01F4;
      stat_arr[0] = 8'h00;
      stat_arr[1] = 8'h00;
      stat_arr[2] = 8'h07;
      stat_n      = 4'd3;
      stat_gen    = stat_gen + 1;

      // reset values
      repeat (3) @(negedge fastclk);
      check("rst_busy",      32'(busy), 0);
      check("rst_cmd_valid", 32'(cmd_valid), 0);
      check("rst_distance",  32'(distance), 0);
      check("rst_dist_valid",32'(dist_valid), 0);
      check("rst_err",       32'(err), 0);
      check("rst_err_code",  32'(err_code), 0);
      rst = 1'b0;
      repeat (2) @(negedge fastclk);

      // 1: status 0,0,7 then result 0x01F4
      pulse_start();
      check("t1_busy", 32'(busy), 1);
      check("t1_first_reg", 32'(cmd_reg), 32'h00);
      check("t1_first_wdata", 32'(cmd_wdata), 32'h01);
      check("t1_dev", 32'(cmd_dev), 32'h29);
      wait_idle(2000, ok);
      repeat (2) @(negedge fastclk);
      check("t1_done", 32'(ok), 1);
      check("t1_int_reads", n_int_rd, 3);
      check("t1_reads", n_rd, 4);
      check("t1_cmds", n_cmds, 6);
      check("t1_distance", 32'(distance), 32'h01F4);
      check("t1_dv_pulses", dv_cnt, 1);
      check("t1_err", 32'(err), 0);
      check("t1_last_reg", 32'(last_reg), 32'h0B);
      check("t1_last_wdata", 32'(last_wdata), 32'h01);

      // 2: NACK on the start write
      nack_en  = 1'b1;
      nack_reg = 8'h00;
      b_cmds   = n_cmds;
      pulse_start();
      wait_idle(500, ok);
      repeat (20) @(negedge fastclk);
      check("t2_done", 32'(ok), 1);
      check("t2_err", 32'(err), 1);
      check("t2_err_code", 32'(err_code), 1);
      check("t2_cmds", n_cmds - b_cmds, 1);
      check("t2_distance", 32'(distance), 32'h01F4);
      check("t2_dv_pulses", dv_cnt, 1);

      // 3: status never ready -> poll timeout after POLL_MAX=4 reads
      nack_en      = 1'b0;
      stat_n       = 4'd0;
      stat_default = 8'h00;
      stat_gen     = stat_gen + 1;
      b_int        = n_int_rd;
      pulse_start();
      check("t3_err_cleared", 32'(err), 0);
      check("t3_code_cleared", 32'(err_code), 0);
      wait_idle(1000, ok);
      repeat (2) @(negedge fastclk);
      check("t3_done", 32'(ok), 1);
      check("t3_int_reads", n_int_rd - b_int, 4);
      check("t3_err_code", 32'(err_code), 2);
      check("t3_err", 32'(err), 1);
      check("t3_dv_pulses", dv_cnt, 1);

      // 4: ready withheld 50 cycles, cmd_* must hold
      ready_delay = 50;
      stat_arr[0] = 8'h07;
      stat_n      = 4'd1;
      stat_gen    = stat_gen + 1;
      res_data    = 16'h0ABC;
      b_cmds      = n_cmds;
      pulse_start();
      s_reg   = cmd_reg;
      s_wdata = cmd_wdata;
      s_rw    = cmd_rw;
      s_rlen  = cmd_rlen;
      stable  = cmd_valid;
      for (int i = 0; i < 50; i++) begin
         @(negedge fastclk);
         if (!cmd_valid || cmd_reg != s_reg || cmd_wdata != s_wdata ||
             cmd_rw != s_rw || cmd_rlen != s_rlen) stable = 1'b0;
      end
      check("t4_stable", 32'(stable), 1);
      check("t4_snap_reg", 32'(s_reg), 32'h00);
      check("t4_none_accepted", n_cmds - b_cmds, 0);
      repeat (2) @(negedge fastclk);
      check("t4_one_accepted", n_cmds - b_cmds, 1);
      wait_idle(2000, ok);
      repeat (2) @(negedge fastclk);
      check("t4_done", 32'(ok), 1);
      check("t4_distance", 32'(distance), 32'h0ABC);
      check("t4_err", 32'(err), 0);

      // 5: continuous mode, 100-cycle period, cont_en dropped mid-poll
      ready_delay  = 0;
      stat_n       = 4'd0;
      stat_default = 8'h01;
      stat_gen     = stat_gen + 1;
      res_data     = 16'h0064;
      b_dv         = dv_cnt;
      cont_en      = 1'b1;
      ok           = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge fastclk);
         if (dv_cnt >= b_dv + 2) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_two_shots", 32'(ok), 1);
      check("t5_gap", last_gap, 100);
      check("t5_busy_in_period", 32'(busy), 1);
      stat_arr[0] = 8'h00;
      stat_arr[1] = 8'h00;
      stat_n      = 4'd2;
      stat_gen    = stat_gen + 1;
      b_int       = n_int_rd;
      ok          = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge fastclk);
         if (n_int_rd >= b_int + 1) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_poll_started", 32'(ok), 1);
      cont_en = 1'b0;
      wait_idle(1000, ok);
      repeat (2) @(negedge fastclk);
      check("t5_done", 32'(ok), 1);
      check("t5_shots", dv_cnt - b_dv, 3);
      check("t5_last_polls", n_int_rd - b_int, 3);
      check("t5_distance", 32'(distance), 32'h0064);
      b_cmds = n_cmds;
      repeat (300) @(negedge fastclk);
      check("t5_stays_idle", n_cmds - b_cmds, 0);
      check("t5_busy_low", 32'(busy), 0);

      // 6: reset while waiting for the result read
      rsp_lat     = 30;
      stat_arr[0] = 8'h07;
      stat_n      = 4'd1;
      stat_gen    = stat_gen + 1;
      res_data    = 16'h1234;
      b_res       = n_res_rd;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge fastclk);
         if (n_res_rd > b_res) begin
            ok = 1'b1;
            break;
         end
      end
      check("t6_res_issued", 32'(ok), 1);
      repeat (3) @(negedge fastclk);
      check("t6_busy_before", 32'(busy), 1);
      #1 rst = 1'b1;
      #1;
      check("t6_busy", 32'(busy), 0);
      check("t6_cmd_valid", 32'(cmd_valid), 0);
      check("t6_dist_valid", 32'(dist_valid), 0);
      check("t6_distance", 32'(distance), 0);
      @(negedge fastclk);
      rst     = 1'b0;
      rsp_lat = 2;
      b_dv    = dv_cnt;
      repeat (40) @(negedge fastclk);
      check("t6_idle_after", 32'(busy), 0);
      check("t6_no_dv", dv_cnt - b_dv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
